memory_stage_access: RTL and testbench

Memory-stage access controller that consumes the execute/memory pipeline register outputs and performs loads and stores against a multi-cycle, ready-handshaked data memory. It stalls upstream pipeline registers while an access is outstanding and registers the completed result into the memory/writeback boundary. Non-memory instructions pass through with one cycle of latency.

---
 rtl/memory_stage_pkg.sv | 20 ++
 rtl/memory_stage_access_timer.sv | 18 +
 rtl/memory_stage_access.sv | 95 +++++++++
 tb/tb_memory_stage_access.sv | 116 +++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: shared types and constants for the memory-stage access controller
package memory_stage_pkg;
    localparam int DATA_W = 16;
    localparam logic BUBBLE_WRE = 1'b0;
    localparam logic BUBBLE_SEL = 1'b0;
    typedef enum logic {IDLE, WAIT} state_t;
    typedef struct packed {
        logic              req;
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;
    typedef struct packed {
        logic              wre;
        logic              sel;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] rdata;
        logic [DATA_W-1:0] rd;
    } wb_t;
endpackage

// File: rtl/memory_stage_access_timer.sv
// memory_wait_timer: counts not-ready WAIT cycles and flags the last one before abandoning
module memory_wait_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    logic [7:0] count_q, count_d;
    always_comb count_d = clear_i ? 8'd0 : enable_i ? count_q + 8'd1 : count_q;
    always_ff @(posedge clk) begin
        if (reset) count_q <= 8'd0;
        else       count_q <= count_d;
    end
    assign expired_o = count_q == 8'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/memory_stage_access.sv
// memory_stage_access: drives a ready-handshaked data memory for loads/stores, stalls upstream
// while waiting, and registers results into the memory/writeback boundary.
module memory_stage_access
    import memory_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wre_memory,
    input  logic              select_writeback_data_mux_memory,
    input  logic              write_memory_enable_memory,
    input  logic [DATA_W-1:0] ALUresult_memory,
    input  logic [DATA_W-1:0] srcB_memory,
    input  logic [DATA_W-1:0] rd_memory,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              wre_writeback,
    output logic              select_writeback_data_mux_writeback,
    output logic [DATA_W-1:0] ALUresult_writeback,
    output logic [DATA_W-1:0] read_data_writeback,
    output logic [DATA_W-1:0] rd_writeback,
    output logic              mem_error
);
    state_t state_q, state_d;
    req_t   req_q, req_d;
    wb_t    wb_q, wb_d;
    logic   err_q, err_d;
    logic   store, load, access, expired, done, abort;
    assign store  = write_memory_enable_memory;
    assign load   = select_writeback_data_mux_memory & ~store;
    assign access = load | store;
    assign done   = state_q == WAIT && mem_ready;
    assign abort  = state_q == WAIT && !mem_ready && expired;
    memory_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (state_q == IDLE),
        .enable_i (state_q == WAIT && !mem_ready),
        .expired_o(expired)
    );
    // The final timeout cycle releases the stall so the instruction retires as a bubble
    assign stall = !reset && ((state_q == IDLE && access) || (state_q == WAIT && !mem_ready && !expired));
    always_comb begin
        state_d = state_q == IDLE ? (access ? WAIT : IDLE) : (done || abort) ? IDLE : WAIT;
        req_d   = req_q;
        wb_d    = wb_q;
        err_d   = err_q | abort;
        if (state_q == IDLE) begin
            if (access) begin
                req_d  = '{req: 1'b1, we: store, addr: ALUresult_memory, wdata: srcB_memory};
                wb_d.wre = BUBBLE_WRE;
                wb_d.sel = BUBBLE_SEL;
            end else begin
                wb_d = '{wre: wre_memory, sel: 1'b0, alu: ALUresult_memory, rdata: wb_q.rdata, rd: rd_memory};
            end
        end else if (done) begin
            req_d.req = 1'b0;
            wb_d = '{wre: wre_memory, sel: load, alu: ALUresult_memory,
                     rdata: load ? mem_rdata : wb_q.rdata, rd: rd_memory};
        end else if (abort) begin
            req_d.req = 1'b0;
            wb_d.wre  = BUBBLE_WRE;
            wb_d.sel  = BUBBLE_SEL;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            wb_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wb_q    <= wb_d;
            err_q   <= err_d;
        end
    end
    assign mem_req                             = req_q.req;
    assign mem_we                              = req_q.we;
    assign mem_addr                            = req_q.addr;
    assign mem_wdata                           = req_q.wdata;
    assign wre_writeback                       = wb_q.wre;
    assign select_writeback_data_mux_writeback = wb_q.sel;
    assign ALUresult_writeback                 = wb_q.alu;
    assign read_data_writeback                 = wb_q.rdata;
    assign rd_writeback                        = wb_q.rd;
    assign mem_error                           = err_q;
endmodule

// File: tb/tb_memory_stage_access.sv
// tb_memory_stage_access: transaction-level randomized check of the memory-stage controller
module tb_memory_stage_access;
    localparam int TMO = 4;
    logic        clk = 0, reset = 1;
    logic        wre_m = 0, sel_m = 0, we_m = 0;
    logic [15:0] alu_m = 0, srcb_m = 0, rd_m = 0;
    logic        mem_req, mem_we, mem_ready = 0, stall;
    logic [15:0] mem_addr, mem_wdata, mem_rdata = 0;
    logic        wre_wb, sel_wb, mem_error;
    logic [15:0] alu_wb, rdata_wb, rd_wb;
    int          tests = 0, fails = 0;
    logic [15:0] m_rdata = 0;
    logic        m_err = 0;
    always #5 clk = ~clk;
    memory_stage_access #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .wre_memory(wre_m), .select_writeback_data_mux_memory(sel_m),
        .write_memory_enable_memory(we_m), .ALUresult_memory(alu_m),
        .srcB_memory(srcb_m), .rd_memory(rd_m),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall(stall),
        .wre_writeback(wre_wb), .select_writeback_data_mux_writeback(sel_wb),
        .ALUresult_writeback(alu_wb), .read_data_writeback(rdata_wb),
        .rd_writeback(rd_wb), .mem_error(mem_error)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // Presents one instruction; memory answers after lat not-ready WAIT cycles (lat >= TMO never answers)
    task automatic run_instr(input logic w, input logic ld, input logic st, input logic [15:0] a,
                             input logic [15:0] b, input logic [15:0] r, input int lat,
                             input logic [15:0] rv);
        int stalls = 0, reqs = 0, cyc = 0;
        logic s, acc, timed_out;
        acc = ld | st;
        timed_out = acc && lat >= TMO;
        wre_m = w; sel_m = ld; we_m = st; alu_m = a; srcb_m = b; rd_m = r;
        do begin
            if (mem_req) begin
                check("req_we", mem_we, st);
                check("req_addr", mem_addr, a);
                check("req_wdata", mem_wdata, b);
                mem_ready = reqs == lat;
                mem_rdata = mem_ready ? rv : 16'($urandom);
                reqs++;
            end else begin
                mem_ready = 1'($urandom);
                mem_rdata = 16'($urandom);
            end
            #1 s = stall;
            stalls += int'(s);
            @(posedge clk); #1;
            cyc++;
        end while (s && cyc < 50);
        mem_ready = 0;
        check("stall_cycles", stalls, !acc ? 0 : timed_out ? TMO : lat + 1);
        check("req_cycles", reqs, !acc ? 0 : timed_out ? TMO : lat + 1);
        check("req_dropped", mem_req, 0);
        if (timed_out) begin
            m_err = 1;
            check("bubble_wre", wre_wb, 0);
            check("bubble_sel", sel_wb, 0);
        end else begin
            if (ld && !st) m_rdata = rv;
            check("wb_wre", wre_wb, w);
            check("wb_sel", sel_wb, ld && !st);
            check("wb_alu", alu_wb, a);
            check("wb_rd", rd_wb, r);
        end
        check("wb_rdata", rdata_wb, m_rdata);
        check("mem_error", mem_error, m_err);
    endtask
    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, {mem_req, mem_we, mem_addr, mem_wdata}, 0);
        check({tag, "_wb"}, {wre_wb, sel_wb, alu_wb, rd_wb}, 0);
        check({tag, "_rdata"}, rdata_wb, 0);
        check({tag, "_err"}, mem_error, 0);
    endtask
    initial begin
        sel_m = 1; alu_m = 16'h0100;
        repeat (2) @(posedge clk);
        #1 check("stall_in_reset", stall, 0);
        check_all_zero("reset");
        reset = 0; sel_m = 0; alu_m = 0;
        run_instr(1, 0, 0, 16'h0042, 16'h0, 16'd3, 0, 16'h0);
        run_instr(1, 1, 0, 16'h0100, 16'h0, 16'd5, 0, 16'hBEEF);
        run_instr(0, 0, 1, 16'h0200, 16'h1234, 16'd6, 3, 16'h0);
        run_instr(1, 1, 0, 16'h0300, 16'h0, 16'd7, TMO, 16'h0);
        run_instr(1, 0, 0, 16'h0055, 16'h0, 16'd8, 0, 16'h0);
        run_instr(0, 1, 1, 16'h0400, 16'h5678, 16'd9, 1, 16'h0);
        // Reset in the middle of an outstanding load, then a late ready must be ignored
        wre_m = 1; sel_m = 1; we_m = 0; alu_m = 16'h0500; rd_m = 16'd2;
        repeat (2) @(posedge clk);
        #1 check("pre_reset_req", mem_req, 1);
        reset = 1;
        @(posedge clk); #1;
        check_all_zero("mid_reset");
        reset = 0; wre_m = 0; sel_m = 0; alu_m = 0; rd_m = 0;
        m_rdata = 0; m_err = 0;
        mem_ready = 1; mem_rdata = 16'hDEAD;
        @(posedge clk); #1;
        mem_ready = 0;
        check_all_zero("late_ready");
        for (int i = 0; i < 200; i++) begin
            int k = $urandom_range(0, 3);
            run_instr(1'($urandom), k == 1 || k == 3, k >= 2, 16'($urandom), 16'($urandom),
                      16'($urandom), $urandom_range(0, TMO + 1), 16'($urandom));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
